instr_fetch_unit: RTL

Fetch-side initiator for the combinational instruction memory. Holds the program counter and drives the byte address to the memory each cycle. Captures the returned 32-bit word into a small prefetch FIFO and presents {pc, instruction} to decode over a valid/ready handshake. Supports branch/jump redirect with flush, and fetch enable/halt.

---
 rtl/instr_fetch_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : PC holder and prefetch FIFO feeding decode over valid/ready,
//            with redirect flush and fetch enable. Optional perf counters
//            are enabled by defining IFETCH_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [31:0]        r_fetch_pc;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_fifo_pc    [FIFO_DEPTH];
    logic [31:0]        r_fifo_instr [FIFO_DEPTH];

    logic               w_valid;
    logic               w_full;
    logic               w_pop;
    logic               w_push;

    assign w_valid   = (r_count != '0);
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop     = w_valid && out_ready;
    assign imem_addr = r_fetch_pc;
    assign out_valid = w_valid;
    assign out_instr = w_valid ? r_fifo_instr[r_rd_ptr] : 32'h0;
    assign out_pc    = w_valid ? r_fifo_pc[r_rd_ptr]    : 32'h0;

    // Redirect freezes the FSM and suppresses any push for that cycle.
    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        if (!redirect_valid) begin
            case (r_state)
                IDLE: begin
                    if (fetch_en) begin
                        w_state_next = RUN;
                    end
                end
                RUN: begin
                    if (!fetch_en) begin
                        w_state_next = IDLE;
                    end else if (!w_full || w_pop) begin
                        w_push = 1'b1;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_fetch_pc <= {RESET_PC[31:2], 2'b00};
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_state_next;
            if (redirect_valid) begin
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_push) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                    r_wr_ptr   <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage needs no reset: occupancy alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_fetch_pc;
            r_fifo_instr[r_wr_ptr] <= imem_instr;
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= 32'h0;
            r_perf_stall   <= 32'h0;
        end else begin
            if (w_push) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_valid && !out_ready) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule
`default_nettype wire
